// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic array sequencer.
package systolic_pkg;

  localparam int N_DEF   = 4;
  localparam int K_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    READ
  } state_e;

endpackage

// File: rtl/systolic_lane_mask.sv
// Combinational per-lane feed-valid generator for the skewed operand feed.
module systolic_lane_mask
  import systolic_pkg::*;
#(
  parameter int N   = N_DEF,
  parameter int K_W = K_W_DEF
) (
  input  logic [K_W:0]   feed_idx_i,
  input  logic [K_W-1:0] k_len_i,
  output logic [N-1:0]   lane_valid_o
);

  // Lane r lags the base counter by r; the extra index bit keeps idx - r from wrapping.
  for (genvar r = 0; r < N; r++) begin : g_lane
    logic [K_W:0] laneOfs;
    assign laneOfs = feed_idx_i - (K_W+1)'(r);
    assign lane_valid_o[r] = (feed_idx_i >= (K_W+1)'(r)) && (laneOfs < {1'b0, k_len_i});
  end

endmodule

// File: rtl/systolic_ctrl.sv
// Sequencer for an NxN systolic array: clear, skewed feed, pipeline drain, and
// row-by-row result handshake.
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int K_W      = K_W_DEF,
  parameter int PIPE_LAT = 4,
  parameter int RD_LAT   = 1,
  localparam int ROW_W   = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [K_W-1:0]   k_len_i,
  input  logic [31:0]      cfg_offset_i,
  output logic [31:0]      offset_o,
  output logic             busy_o,
  output logic             pe_rst_n_o,
  output logic [K_W-1:0]   feed_idx_o,
  output logic [N-1:0]     lane_valid_o,
  output logic [ROW_W-1:0] rd_row_o,
  output logic             rd_valid_o,
  input  logic             rd_ready_i,
  output logic             done_o
);

  localparam int DRAIN_CYC = N - 1 + PIPE_LAT + RD_LAT;

  state_e           state_q;
  logic [K_W-1:0]   kLen_q;
  logic [31:0]      offset_q;
  logic             busy_q;
  logic             peRstN_q;
  logic [K_W:0]     feedCnt_q;
  logic [K_W:0]     feedCnt_d;
  logic [K_W:0]     lastIdx;
  logic [N-1:0]     laneValid_q;
  logic [N-1:0]     laneValid_d;
  logic [7:0]       drainCnt_q;
  logic [ROW_W-1:0] rdRow_q;
  logic             rdValid_q;
  logic             done_q;

  // Counter runs one bit wider than the port so k_len near 2^K_W never wraps.
  assign lastIdx   = {1'b0, kLen_q} + (K_W+1)'(N - 2);
  assign feedCnt_d = (state_q == CLEAR) ? '0 : feedCnt_q + (K_W+1)'(1);

  systolic_lane_mask #(
    .N   (N),
    .K_W (K_W)
  ) u_lane_mask (
    .feed_idx_i   (feedCnt_d),
    .k_len_i      (kLen_q),
    .lane_valid_o (laneValid_d)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      kLen_q      <= '0;
      offset_q    <= '0;
      busy_q      <= 1'b0;
      peRstN_q    <= 1'b0;
      feedCnt_q   <= '0;
      laneValid_q <= '0;
      drainCnt_q  <= '0;
      rdRow_q     <= '0;
      rdValid_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          peRstN_q <= 1'b1;
          if (start_i) begin
            kLen_q   <= k_len_i;
            offset_q <= cfg_offset_i;
            busy_q   <= 1'b1;
            peRstN_q <= 1'b0;
            state_q  <= CLEAR;
          end
        end
        CLEAR: begin
          peRstN_q   <= 1'b1;
          feedCnt_q  <= feedCnt_d;
          drainCnt_q <= '0;
          if (kLen_q == '0) begin
            state_q <= DRAIN;
          end else begin
            laneValid_q <= laneValid_d;
            state_q     <= FEED;
          end
        end
        FEED: begin
          if (feedCnt_q == lastIdx) begin
            laneValid_q <= '0;
            drainCnt_q  <= '0;
            state_q     <= DRAIN;
          end else begin
            feedCnt_q   <= feedCnt_d;
            laneValid_q <= laneValid_d;
          end
        end
        DRAIN: begin
          if (drainCnt_q == 8'(DRAIN_CYC - 1)) begin
            rdRow_q   <= '0;
            rdValid_q <= 1'b1;
            state_q   <= READ;
          end else begin
            drainCnt_q <= drainCnt_q + 8'd1;
          end
        end
        READ: begin
          if (rd_ready_i) begin
            if (rdRow_q == ROW_W'(N - 1)) begin
              rdRow_q   <= '0;
              rdValid_q <= 1'b0;
              done_q    <= 1'b1;
              busy_q    <= 1'b0;
              state_q   <= IDLE;
            end else begin
              rdRow_q <= rdRow_q + ROW_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign offset_o     = offset_q;
  assign busy_o       = busy_q;
  assign pe_rst_n_o   = peRstN_q;
  assign feed_idx_o   = feedCnt_q[K_W-1:0];
  assign lane_valid_o = laneValid_q;
  assign rd_row_o     = rdRow_q;
  assign rd_valid_o   = rdValid_q;
  assign done_o       = done_q;

endmodule
